// File: rtl/pe_tile_sequencer_if.sv
// Host/PE-group facing signal bundle for pe_tile_sequencer.
// The master modport is the host/PE-group side; the slave modport is the sequencer.
interface pe_tile_sequencer_if #(
    parameter int W_PEAddrWidth   = 2,
    parameter int O_PEAddrWidth   = 2,
    parameter int I_PEAddrWidth   = 3,
    parameter int BlockCountWidth = 3,
    parameter int TileCountWidth  = 8
);
    logic                       Start;
    logic                       Abort;
    logic [TileCountWidth-1:0]  Num_Tiles;
    logic                       EN_W;
    logic                       EN_I;
    logic                       EN_O_In;
    logic                       EN_O_Out;
    logic                       W_Load_En;
    logic                       I_Load_En;
    logic                       O_In_Load_En;
    logic                       O_Drain_En;
    logic [W_PEAddrWidth-1:0]   W_PEAddr;
    logic [I_PEAddrWidth-1:0]   I_PEAddr;
    logic [O_PEAddrWidth-1:0]   O_In_PEAddr;
    logic [O_PEAddrWidth-1:0]   O_Out_PEAddr;
    logic [BlockCountWidth-1:0] I_Block_Counter;
    logic [BlockCountWidth-1:0] O_In_Block_Counter;
    logic                       I_BLOCK_EQUAL_TO_ZERO;
    logic                       O_IN_BLOCK_EQUAL_TO_ZERO;
    logic [TileCountWidth-1:0]  Tile_Counter;
    logic                       Busy;
    logic                       Tile_Done;
    logic                       Done;
    logic [31:0]                Stall_Cycles;

    modport master (
        output Start, Abort, Num_Tiles, EN_W, EN_I, EN_O_In, EN_O_Out,
        input  W_Load_En, I_Load_En, O_In_Load_En, O_Drain_En,
               W_PEAddr, I_PEAddr, O_In_PEAddr, O_Out_PEAddr,
               I_Block_Counter, O_In_Block_Counter,
               I_BLOCK_EQUAL_TO_ZERO, O_IN_BLOCK_EQUAL_TO_ZERO,
               Tile_Counter, Busy, Tile_Done, Done, Stall_Cycles
    );

    modport slave (
        input  Start, Abort, Num_Tiles, EN_W, EN_I, EN_O_In, EN_O_Out,
        output W_Load_En, I_Load_En, O_In_Load_En, O_Drain_En,
               W_PEAddr, I_PEAddr, O_In_PEAddr, O_Out_PEAddr,
               I_Block_Counter, O_In_Block_Counter,
               I_BLOCK_EQUAL_TO_ZERO, O_IN_BLOCK_EQUAL_TO_ZERO,
               Tile_Counter, Busy, Tile_Done, Done, Stall_Cycles
    );
endinterface

// File: rtl/pe_tile_sequencer.sv
// Tile scheduler for one PE group: weight-load / stream / drain phases per tile.
// Optional stall performance counter is built only when PE_SEQ_PERF_EN is defined.
module pe_tile_sequencer #(
    parameter int W_PEGroupSize   = 4,
    parameter int O_PEGroupSize   = 4,
    parameter int I_PEGroupSize   = 7,
    parameter int W_PEAddrWidth   = 2,
    parameter int O_PEAddrWidth   = 2,
    parameter int I_PEAddrWidth   = 3,
    parameter int BlockCount      = 4,
    parameter int BlockCountWidth = 3,
    parameter int TileCountWidth  = 8
) (
    input  logic                    clk,
    input  logic                    aclr,
    pe_tile_sequencer_if.slave      bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_FINISH} state_t;

    localparam logic [W_PEAddrWidth-1:0]   W_LAST   = W_PEAddrWidth'(W_PEGroupSize - 1);
    localparam logic [I_PEAddrWidth-1:0]   I_LAST   = I_PEAddrWidth'(I_PEGroupSize - 1);
    localparam logic [I_PEAddrWidth-1:0]   I_RELOAD = I_PEAddrWidth'(W_PEGroupSize - 1);
    localparam logic [O_PEAddrWidth-1:0]   O_LAST   = O_PEAddrWidth'(O_PEGroupSize - 1);
    localparam logic [BlockCountWidth-1:0] BLK_MAX  = BlockCountWidth'(BlockCount);
    localparam logic [BlockCountWidth-1:0] BLK_LAST = BlockCountWidth'(BlockCount - 1);
    localparam logic [TileCountWidth-1:0]  TILE_ONE = TileCountWidth'(1);

    state_t                     r_state;
    logic [TileCountWidth-1:0]  r_num_tiles;
    logic [TileCountWidth-1:0]  r_tile_cnt;
    logic [W_PEAddrWidth-1:0]   r_w_addr;
    logic [I_PEAddrWidth-1:0]   r_i_addr;
    logic [O_PEAddrWidth-1:0]   r_oi_addr;
    logic [O_PEAddrWidth-1:0]   r_oo_addr;
    logic [BlockCountWidth-1:0] r_i_blk;
    logic [BlockCountWidth-1:0] r_o_blk;
    logic                       r_tile_done;
    logic                       r_done;

    logic w_busy, w_i_met, w_o_met;
    logic w_w_gate, w_i_gate, w_oi_gate, w_oo_gate;
    logic w_w_fire, w_i_fire, w_oi_fire, w_oo_fire;
    logic w_i_wrap, w_o_wrap, w_i_done, w_o_done, w_start_ok;

    assign w_busy     = (r_state != S_IDLE);
    assign w_i_met    = (r_i_blk == BLK_MAX);
    assign w_o_met    = (r_o_blk == BLK_MAX);
    assign w_w_gate   = (r_state == S_LOAD_W);
    assign w_i_gate   = (r_state == S_STREAM) && !w_i_met;
    assign w_oi_gate  = (r_state == S_STREAM) && !w_o_met;
    assign w_oo_gate  = (r_state == S_DRAIN);
    assign w_w_fire   = bus.EN_W     && w_w_gate;
    assign w_i_fire   = bus.EN_I     && w_i_gate;
    assign w_oi_fire  = bus.EN_O_In  && w_oi_gate;
    assign w_oo_fire  = bus.EN_O_Out && w_oo_gate;
    assign w_i_wrap   = w_i_fire  && (r_i_addr  == I_LAST);
    assign w_o_wrap   = w_oi_fire && (r_oi_addr == O_LAST);
    // Quota considered met on the strobe that completes it, so both sides finishing together exit at once
    assign w_i_done   = w_i_met || (w_i_wrap && (r_i_blk == BLK_LAST));
    assign w_o_done   = w_o_met || (w_o_wrap && (r_o_blk == BLK_LAST));
    assign w_start_ok = (r_state == S_IDLE) && bus.Start && (bus.Num_Tiles != '0);

    always_ff @(posedge clk) begin
        if (aclr || bus.Abort) begin
            r_state     <= S_IDLE;
            r_num_tiles <= '0;
            r_tile_cnt  <= '0;
            r_w_addr    <= '0;
            r_i_addr    <= '0;
            r_oi_addr   <= '0;
            r_oo_addr   <= '0;
            r_i_blk     <= '0;
            r_o_blk     <= '0;
            r_tile_done <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_tile_done <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_num_tiles <= bus.Num_Tiles;
                        r_tile_cnt  <= '0;
                        r_state     <= S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (w_w_fire) begin
                        if (r_w_addr == W_LAST) begin
                            r_w_addr <= '0;
                            r_state  <= S_STREAM;
                        end else begin
                            r_w_addr <= r_w_addr + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_i_done && w_o_done) begin
                        r_i_addr  <= '0;
                        r_oi_addr <= '0;
                        r_i_blk   <= '0;
                        r_o_blk   <= '0;
                        r_state   <= S_DRAIN;
                    end else begin
                        // Blocks after the first only feed the edge PEs not reachable internally
                        if (w_i_wrap) begin
                            r_i_addr <= I_RELOAD;
                            r_i_blk  <= r_i_blk + 1'b1;
                        end else if (w_i_fire) begin
                            r_i_addr <= r_i_addr + 1'b1;
                        end
                        if (w_o_wrap) begin
                            r_oi_addr <= '0;
                            r_o_blk   <= r_o_blk + 1'b1;
                        end else if (w_oi_fire) begin
                            r_oi_addr <= r_oi_addr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_oo_fire) begin
                        if (r_oo_addr == O_LAST) begin
                            r_oo_addr   <= '0;
                            r_tile_done <= 1'b1;
                            if (r_tile_cnt == r_num_tiles - TILE_ONE) begin
                                r_state <= S_FINISH;
                            end else begin
                                r_tile_cnt <= r_tile_cnt + 1'b1;
                                r_state    <= S_LOAD_W;
                            end
                        end else begin
                            r_oo_addr <= r_oo_addr + 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PE_SEQ_PERF_EN
    logic [31:0] r_stall;
    logic        w_any_fire;

    assign w_any_fire = w_w_fire || w_i_fire || w_oi_fire || w_oo_fire;

    always_ff @(posedge clk) begin
        if (aclr || bus.Abort || w_start_ok) begin
            r_stall <= '0;
        end else if (w_busy && !w_any_fire && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign bus.Stall_Cycles = r_stall;
`else
    assign bus.Stall_Cycles = 32'd0;
`endif

    assign bus.W_Load_En                = w_w_gate;
    assign bus.I_Load_En                = w_i_gate;
    assign bus.O_In_Load_En             = w_oi_gate;
    assign bus.O_Drain_En               = w_oo_gate;
    assign bus.W_PEAddr                 = r_w_addr;
    assign bus.I_PEAddr                 = r_i_addr;
    assign bus.O_In_PEAddr              = r_oi_addr;
    assign bus.O_Out_PEAddr             = r_oo_addr;
    assign bus.I_Block_Counter          = r_i_blk;
    assign bus.O_In_Block_Counter       = r_o_blk;
    assign bus.I_BLOCK_EQUAL_TO_ZERO    = w_busy && (r_i_blk == '0);
    assign bus.O_IN_BLOCK_EQUAL_TO_ZERO = w_busy && (r_o_blk == '0);
    assign bus.Tile_Counter             = r_tile_cnt;
    assign bus.Busy                     = w_busy;
    assign bus.Tile_Done                = r_tile_done;
    assign bus.Done                     = r_done;
endmodule
